i2c_slave_mem_sequencer: RTL and testbench

//   Byte-level controller between the I2C slave bit engine and the slave address/data memory.

---
 rtl/i2c_slave_mem_sequencer.sv | 160 ++++++++++++++++
 tb/tb_i2c_slave_mem_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_mem_sequencer.sv
// i2c_slave_mem_sequencer: byte-level sequencer turning I2C bytes/read slots into memory lookup/write/read commands
module i2c_slave_mem_sequencer #(
    parameter int ADDRESSLENGTH = 8,
    parameter int ADDRESSNUM    = 2,
    parameter int NBYTES        = 2,
    parameter int MEM_LAT       = 1
) (
    input  logic                     Clk,
    input  logic                     nReset,
    input  logic                     StartDet,
    input  logic                     StopDet,
    input  logic                     ByteValid,
    input  logic [7:0]               RxByte,
    input  logic                     TxReq,
    input  logic                     MasterNack,
    output logic                     MemEnable,
    output logic                     MemMode,
    output logic                     MemRorW,
    output logic [ADDRESSLENGTH-1:0] MemDir,
    output logic [7:0]               MemWData,
    input  logic                     AddressFound,
    input  logic [7:0]               MemRData,
    output logic                     AckValid,
    output logic                     AckOut,
    output logic                     TxValid,
    output logic [7:0]               TxByte,
    output logic                     Busy,
    output logic                     ErrOverrun
);
    localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int CW = $clog2(NBYTES + 1);

    if (ADDRESSNUM < 1 || NBYTES < 1 || MEM_LAT < 1) begin : g_param_check
        $error("i2c_slave_mem_sequencer: ADDRESSNUM, NBYTES and MEM_LAT must be >= 1");
    end

    typedef enum logic [3:0] {
        IDLE, ADDR_ISSUE, ADDR_WAIT, WR_IDLE, WR_ISSUE, WR_WAIT, RD_IDLE, RD_ISSUE, RD_WAIT, IGNORE
    } state_t;

    state_t        state, state_nx;
    logic [LW-1:0] lat;
    logic [CW-1:0] cnt;
    logic          addr_exp, rw, dummy, rd_ign;
    logic          issue, in_flight, wait_done, full;

    assign issue     = state inside {ADDR_ISSUE, WR_ISSUE, RD_ISSUE};
    assign in_flight = issue || state inside {ADDR_WAIT, WR_WAIT, RD_WAIT};
    assign wait_done = lat == LW'(MEM_LAT - 1);
    assign full      = cnt == CW'(NBYTES);

    // State register
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nx;
    end

    // Next state; bus START/STOP override everything, including in-flight commands
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (ByteValid && addr_exp) state_nx = ADDR_ISSUE;
            ADDR_ISSUE: state_nx = ADDR_WAIT;
            ADDR_WAIT:  if (wait_done) state_nx = !AddressFound ? IGNORE : rw ? RD_IDLE : WR_IDLE;
            WR_IDLE:    if (ByteValid) state_nx = WR_ISSUE;
            WR_ISSUE:   state_nx = WR_WAIT;
            WR_WAIT:    if (wait_done) state_nx = dummy ? IGNORE : WR_IDLE;
            RD_IDLE:    state_nx = MasterNack ? IGNORE : TxReq ? RD_ISSUE : RD_IDLE;
            RD_ISSUE:   state_nx = RD_WAIT;
            RD_WAIT:    if (wait_done) state_nx = rd_ign ? IGNORE : RD_IDLE;
            IGNORE:     state_nx = ByteValid ? WR_ISSUE : TxReq ? RD_ISSUE : IGNORE;
            default:    state_nx = IDLE;
        endcase
        if (StartDet || StopDet) state_nx = IDLE;
    end

    // Strobe and busy; dummy passes through the issue/wait timing without touching memory
    always_comb begin
        MemEnable = issue && !dummy;
        Busy      = state != IDLE;
    end

    // Command fields, byte counter, sticky overrun flag and registered ack/tx responses
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            MemDir     <= '0;
            MemWData   <= '0;
            MemMode    <= 1'b0;
            MemRorW    <= 1'b0;
            AckValid   <= 1'b0;
            AckOut     <= 1'b0;
            TxValid    <= 1'b0;
            TxByte     <= '0;
            ErrOverrun <= 1'b0;
            lat        <= '0;
            cnt        <= '0;
            addr_exp   <= 1'b0;
            rw         <= 1'b0;
            dummy      <= 1'b0;
            rd_ign     <= 1'b0;
        end else begin
            AckValid <= 1'b0;
            TxValid  <= 1'b0;
            lat      <= issue ? '0 : lat + 1'b1;
            if (StartDet) begin
                cnt        <= '0;
                addr_exp   <= 1'b1;
                ErrOverrun <= 1'b0;
            end else if (StopDet) begin
                addr_exp <= 1'b0;
            end else begin
                if (in_flight && (ByteValid || TxReq)) ErrOverrun <= 1'b1;
                case (state)
                    IDLE: if (ByteValid && addr_exp) begin
                        MemDir   <= ADDRESSLENGTH'(RxByte[7:1]);
                        MemMode  <= 1'b0;
                        rw       <= RxByte[0];
                        addr_exp <= 1'b0;
                        dummy    <= 1'b0;
                    end
                    ADDR_WAIT: if (wait_done) begin
                        AckValid <= 1'b1;
                        AckOut   <= AddressFound;
                    end
                    WR_IDLE: if (ByteValid) begin
                        dummy <= full;
                        if (!full) begin
                            MemMode  <= 1'b1;
                            MemRorW  <= 1'b1;
                            MemWData <= RxByte;
                            cnt      <= cnt + 1'b1;
                        end
                    end
                    WR_WAIT: if (wait_done) begin
                        AckValid <= 1'b1;
                        AckOut   <= !dummy;
                    end
                    RD_IDLE: if (!MasterNack && TxReq) begin
                        dummy  <= full;
                        rd_ign <= 1'b0;
                        if (!full) begin
                            MemMode <= 1'b1;
                            MemRorW <= 1'b0;
                            cnt     <= cnt + 1'b1;
                        end
                    end
                    RD_WAIT: if (wait_done) begin
                        TxValid <= 1'b1;
                        TxByte  <= dummy ? 8'hFF : MemRData;
                    end
                    IGNORE: if (ByteValid || TxReq) begin
                        dummy  <= 1'b1;
                        rd_ign <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_mem_sequencer.sv
// tb_i2c_slave_mem_sequencer: vector table, corner sequences and random traffic against a transaction-level model
module tb_i2c_slave_mem_sequencer;
    logic       Clk, nReset, StartDet, StopDet, ByteValid, TxReq, MasterNack;
    logic [7:0] RxByte, MemRData;
    logic       AddressFound;
    logic       MemEnable, MemMode, MemRorW, AckValid, AckOut, TxValid, Busy, ErrOverrun;
    logic [7:0] MemDir, MemWData, TxByte;
    logic [31:0] outs;

    i2c_slave_mem_sequencer dut (
        .Clk(Clk), .nReset(nReset), .StartDet(StartDet), .StopDet(StopDet),
        .ByteValid(ByteValid), .RxByte(RxByte), .TxReq(TxReq), .MasterNack(MasterNack),
        .MemEnable(MemEnable), .MemMode(MemMode), .MemRorW(MemRorW), .MemDir(MemDir),
        .MemWData(MemWData), .AddressFound(AddressFound), .MemRData(MemRData),
        .AckValid(AckValid), .AckOut(AckOut), .TxValid(TxValid), .TxByte(TxByte),
        .Busy(Busy), .ErrOverrun(ErrOverrun)
    );

    assign outs = {MemEnable, MemMode, MemRorW, MemDir, MemWData, AckValid, AckOut, TxValid, TxByte, Busy, ErrOverrun};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_cmp = 0, n_bad = 0;
    int got_k, n_pulse, n_en;
    logic [7:0] got_v, en_dir, en_wd;
    logic en_mode, en_rorw;
    logic [31:0] outs_inj;

    typedef struct {
        int pre; logic is_tx; logic [7:0] b; logic found; logic [7:0] rd;
        int ek; logic [7:0] ev; int een; logic emode; logic erorw; logic [7:0] edir; logic [7:0] ewd;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic pulse(input logic [2:0] w);
        @(posedge Clk); #1;
        StartDet = w[2]; StopDet = w[1]; MasterNack = w[0];
        @(posedge Clk); #1;
        StartDet = 0; StopDet = 0; MasterNack = 0;
        @(negedge Clk);
    endtask

    // One byte or read slot at cycle 0, memory answer valid only in cycle 2, optional injection at cycle inj_k
    task automatic op(input logic is_tx, input logic [7:0] b, input logic found, input logic [7:0] rd,
                      input int inj_k, input logic [3:0] inj);
        got_k = 0; got_v = 0; n_pulse = 0; n_en = 0; outs_inj = '1;
        for (int k = 0; k <= 6; k++) begin
            @(posedge Clk); #1;
            ByteValid    = (k == 0 && !is_tx) || (k == inj_k && inj[0]);
            TxReq        = k == 0 && is_tx;
            RxByte       = b;
            StopDet      = k == inj_k && inj[1];
            StartDet     = k == inj_k && inj[2];
            nReset       = !(k == inj_k && inj[3]);
            AddressFound = (k == 2) ? found : !found;
            MemRData     = (k == 2) ? rd : ~rd;
            @(negedge Clk);
            if (k == inj_k && inj[3]) outs_inj = outs;
            if (AckValid || TxValid) begin
                n_pulse++;
                if (got_k == 0) begin
                    got_k = k;
                    got_v = AckValid ? {7'b0, AckOut} : TxByte;
                end
            end
            if (MemEnable) begin
                n_en++;
                en_mode = MemMode; en_rorw = MemRorW; en_dir = MemDir; en_wd = MemWData;
            end
        end
    endtask

    task automatic check_op(input string nm, input int ek, input logic [7:0] ev, input int een);
        if (ek < 0) chk({nm, "_seen"}, got_k != 0, 1);
        else chk({nm, "_lat"}, got_k, ek);
        if (ek != 0) chk({nm, "_val"}, got_v, ev);
        chk({nm, "_npulse"}, n_pulse, ek != 0);
        chk({nm, "_nen"}, n_en, een);
    endtask

    int ph, cnt, r;
    logic [7:0] b, rd;
    logic fnd;

    initial begin
        tbl[0]  = '{1, 0, 8'h1C, 1, 8'h00, 3, 8'h01, 1, 0, 0, 8'h0E, 8'h00};
        tbl[1]  = '{0, 0, 8'h55, 1, 8'h00, 3, 8'h01, 1, 1, 1, 8'h0E, 8'h55};
        tbl[2]  = '{0, 0, 8'hF5, 1, 8'h00, 3, 8'h01, 1, 1, 1, 8'h0E, 8'hF5};
        tbl[3]  = '{0, 0, 8'h33, 1, 8'h00, 3, 8'h00, 0, 0, 0, 8'h00, 8'h00};
        tbl[4]  = '{0, 0, 8'h44, 1, 8'h00, -1, 8'h00, 0, 0, 0, 8'h00, 8'h00};
        tbl[5]  = '{1, 0, 8'h5F, 0, 8'h00, 3, 8'h00, 1, 0, 0, 8'h2F, 8'h00};
        tbl[6]  = '{0, 0, 8'h12, 0, 8'h00, -1, 8'h00, 0, 0, 0, 8'h00, 8'h00};
        tbl[7]  = '{1, 0, 8'h1D, 1, 8'h00, 3, 8'h01, 1, 0, 0, 8'h0E, 8'h00};
        tbl[8]  = '{0, 1, 8'h00, 1, 8'h55, 3, 8'h55, 1, 1, 0, 8'h0E, 8'h00};
        tbl[9]  = '{0, 1, 8'h00, 1, 8'hF5, 3, 8'hF5, 1, 1, 0, 8'h0E, 8'h00};
        tbl[10] = '{0, 1, 8'h00, 1, 8'h3C, 3, 8'hFF, 0, 0, 0, 8'h00, 8'h00};
        tbl[11] = '{2, 0, 8'h22, 1, 8'h00, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00};

        nReset = 0; StartDet = 0; StopDet = 0; ByteValid = 0; TxReq = 0; MasterNack = 0;
        RxByte = 8'h1C; MemRData = 0; AddressFound = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            ByteValid = ~ByteValid;
            @(negedge Clk);
            chk("reset_outs", outs, 0);
        end
        @(posedge Clk); #1;
        nReset = 1; ByteValid = 0;

        foreach (tbl[i]) begin
            if (tbl[i].pre == 1) pulse(3'b100);
            if (tbl[i].pre == 2) pulse(3'b010);
            op(tbl[i].is_tx, tbl[i].b, tbl[i].found, tbl[i].rd, 0, 4'b0);
            check_op($sformatf("vec%0d", i), tbl[i].ek, tbl[i].ev, tbl[i].een);
            if (tbl[i].een != 0) begin
                chk($sformatf("vec%0d_mode", i), en_mode, tbl[i].emode);
                chk($sformatf("vec%0d_dir", i), en_dir, tbl[i].edir);
                if (tbl[i].emode) chk($sformatf("vec%0d_rorw", i), en_rorw, tbl[i].erorw);
                if (tbl[i].emode && tbl[i].erorw) chk($sformatf("vec%0d_wdata", i), en_wd, tbl[i].ewd);
            end
        end
        chk("stop_busy", Busy, 0);

        // Overrun during WR_WAIT, then STOP during WR_WAIT
        pulse(3'b100);
        op(0, 8'h1C, 1, 0, 0, 4'b0);
        check_op("ovr_addr", 3, 1, 1);
        op(0, 8'h55, 1, 0, 2, 4'b0001);
        check_op("ovr_wr", 3, 1, 1);
        chk("ovr_flag", ErrOverrun, 1);
        op(0, 8'hF5, 1, 0, 2, 4'b0010);
        check_op("stop_wait", 0, 0, 1);
        chk("stop_wait_busy", Busy, 0);
        chk("ovr_sticky", ErrOverrun, 1);
        pulse(3'b100);
        chk("ovr_clear", ErrOverrun, 0);

        // START and byte in the same cycle: byte dropped, counter restarts, next byte is an address
        op(0, 8'h1C, 1, 0, 0, 4'b0);
        check_op("sb_addr0", 3, 1, 1);
        op(0, 8'h77, 1, 0, 0, 4'b0100);
        check_op("sb_drop", 0, 0, 0);
        op(0, 8'h1C, 1, 0, 0, 4'b0);
        check_op("sb_addr1", 3, 1, 1);
        chk("sb_addr1_mode", en_mode, 0);
        op(0, 8'h55, 1, 0, 0, 4'b0);
        check_op("sb_wr1", 3, 1, 1);
        op(0, 8'hF5, 1, 0, 0, 4'b0);
        check_op("sb_wr2", 3, 1, 1);
        op(0, 8'h66, 1, 0, 0, 4'b0);
        check_op("sb_wr3", 3, 0, 0);

        // Reset in the middle of a write command
        pulse(3'b100);
        op(0, 8'h1C, 1, 0, 0, 4'b0);
        check_op("mr_addr", 3, 1, 1);
        op(0, 8'h55, 1, 0, 2, 4'b1000);
        check_op("mr_wr", 0, 0, 1);
        chk("mr_outs", outs_inj, 0);
        chk("mr_busy", Busy, 0);

        // Random traffic: phase 0 idle, 1 expect address, 2 write, 3 read, 4 ignore
        ph = 0; cnt = 0;
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                pulse(3'b100);
                ph = 1; cnt = 0;
            end else if (r == 1) begin
                pulse(3'b010);
                ph = 0;
            end else if (ph <= 1) begin
                b = ($urandom_range(0, 2) != 0) ? {($urandom_range(0, 1) == 1) ? 7'h0E : 7'h2A, 1'($urandom)} : 8'($urandom);
                fnd = b[7:1] == 7'h0E || b[7:1] == 7'h2A;
                op(0, b, fnd, 8'h00, 0, 4'b0);
                if (ph == 0) check_op("rnd_idle", 0, 0, 0);
                else begin
                    check_op("rnd_addr", 3, {7'b0, fnd}, 1);
                    chk("rnd_addr_cmd", {en_mode, en_dir}, {1'b0, 1'b0, b[7:1]});
                    ph = !fnd ? 4 : b[0] ? 3 : 2;
                end
            end else if (ph == 2 || (ph == 4 && $urandom_range(0, 1) == 1)) begin
                b = 8'($urandom);
                op(0, b, 1, 8'h00, 0, 4'b0);
                if (ph == 4) check_op("rnd_ign_wr", -1, 8'h00, 0);
                else if (cnt < 2) begin
                    check_op("rnd_wr", 3, 8'h01, 1);
                    chk("rnd_wr_cmd", {en_mode, en_rorw, en_wd}, {2'b11, b});
                    cnt++;
                end else begin
                    check_op("rnd_wr_full", 3, 8'h00, 0);
                    ph = 4;
                end
            end else if (ph == 3 && r == 2) begin
                pulse(3'b001);
                ph = 4;
            end else begin
                rd = 8'($urandom);
                op(1, 8'h00, 1, rd, 0, 4'b0);
                if (ph == 4) check_op("rnd_ign_rd", -1, 8'hFF, 0);
                else if (cnt < 2) begin
                    check_op("rnd_rd", 3, rd, 1);
                    chk("rnd_rd_cmd", {en_mode, en_rorw}, 2'b10);
                    cnt++;
                end else check_op("rnd_rd_full", 3, 8'hFF, 0);
            end
            chk("rnd_busy", Busy, ph >= 2);
            chk("rnd_ovr", ErrOverrun, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
